// File: rtl/rotate_sequencer_if.sv
// Bus bundle between the rotate sequencer and its state memory / offset table.
// start/busy/done: start is taken only while busy is low; done pulses once as the pass ends.
interface rotate_sequencer_if #(
  parameter int W  = 64,
  parameter int AW = 5,
  parameter int OW = 6
);
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_rd_addr;
  logic [W-1:0]  mem_rd_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [W-1:0]  mem_wr_data;
  logic [AW-1:0] off_idx;
  logic [OW-1:0] off_val;

  modport master (
    input  start, mem_rd_data, off_val,
    output busy, done, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, off_idx
  );

  modport slave (
    output start, mem_rd_data, off_val,
    input  busy, done, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, off_idx
  );
endinterface

// File: rtl/rotate_sequencer.sv
// Lane-rotate pass: reads each lane, rotates it left by its table offset one bit
// per cycle, and writes it back in place; done pulses once at the end of the pass.
module rotate_sequencer #(
  parameter int W     = 64,
  parameter int LANES = 25,
  parameter int AW    = 5,
  parameter int OW    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  rotate_sequencer_if.master   bus,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    SHIFT   = 3'd3,
    WRITE   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] lane_idx;
  logic [OW-1:0] cnt;
  logic [W-1:0]  lane_reg;
  logic          last_lane;

  assign last_lane = (lane_idx == AW'(LANES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lane_idx <= '0;
      cnt      <= '0;
      lane_reg <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE:    if (bus.start) lane_idx <= '0;
        CAPTURE: begin
          lane_reg <= bus.mem_rd_data;
          cnt      <= bus.off_val;
        end
        SHIFT: begin
          lane_reg <= {lane_reg[W-2:0], lane_reg[W-1]};
          cnt      <= cnt - OW'(1);
        end
        // The index stays on the last lane after the pass; only start or rst clears it.
        WRITE:   if (!last_lane) lane_idx <= lane_idx + AW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = READ;
      READ:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = (bus.off_val == '0) ? WRITE : SHIFT;
      SHIFT:   if (cnt == OW'(1)) state_nxt = WRITE;
      WRITE:   state_nxt = last_lane ? DONE : READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.mem_wr_en   = (state == WRITE);
  assign bus.mem_rd_addr = lane_idx;
  assign bus.mem_wr_addr = lane_idx;
  assign bus.off_idx     = lane_idx;
  assign bus.mem_wr_data = lane_reg;
  assign state_dbg       = state;

endmodule
